ac_zone_ctrl: RTL and testbench



---
 rtl/ac_zone_ctrl_pkg.sv | 29 ++
 rtl/ac_zone_ctrl_fsm.sv | 100 ++++++++++
 rtl/ac_zone_ctrl.sv | 58 +++++
 tb/tb_ac_zone_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ac_zone_ctrl_pkg.sv
// ============================================================
// ac_pkg : shared state/mode encodings for the zone controller
// Rev 1.0
// ============================================================
`default_nettype none

package ac_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    HEAT    = 2'b01,
    COOL    = 2'b10,
    ILLEGAL = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    OFF       = 2'b00,
    AUTO      = 2'b01,
    HEAT_ONLY = 2'b10,
    COOL_ONLY = 2'b11
  } mode_e;

  function automatic int dwell_w(input int min_dwell);
    return (min_dwell <= 1) ? 1 : $clog2(min_dwell);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ac_zone_ctrl_fsm.sv
// ============================================================
// ac_zone_fsm : one zone's heat/cool/idle FSM with dwell timer
// Rev 1.0
// ============================================================
`default_nettype none

module ac_zone_fsm
  import ac_pkg::*;
#(
  parameter int TEMP_W    = 5,
  parameter int HEAT_ON   = 18,
  parameter int HEAT_OFF  = 20,
  parameter int COOL_ON   = 22,
  parameter int COOL_OFF  = 20,
  parameter int MIN_DWELL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  mode_e             mode,
  input  logic              en,
  input  logic [TEMP_W-1:0] temp,
  output logic              heating,
  output logic              cooling
);

  localparam int              CW         = dwell_w(MIN_DWELL);
  localparam logic [CW-1:0]   DWELL_LOAD = CW'(MIN_DWELL - 1);
  localparam logic [TEMP_W-1:0] C_HEAT_ON  = TEMP_W'(HEAT_ON);
  localparam logic [TEMP_W-1:0] C_HEAT_OFF = TEMP_W'(HEAT_OFF);
  localparam logic [TEMP_W-1:0] C_COOL_ON  = TEMP_W'(COOL_ON);
  localparam logic [TEMP_W-1:0] C_COOL_OFF = TEMP_W'(COOL_OFF);

  if (!(HEAT_ON < HEAT_OFF)) begin : g_chk_heat
    $error("HEAT_ON must be below HEAT_OFF");
  end
  if (!(COOL_OFF < COOL_ON)) begin : g_chk_cool
    $error("COOL_OFF must be below COOL_ON");
  end
  if (!(HEAT_ON < COOL_ON)) begin : g_chk_order
    $error("HEAT_ON must be below COOL_ON");
  end
  if ((HEAT_ON >= (1 << TEMP_W)) || (HEAT_OFF >= (1 << TEMP_W)) ||
      (COOL_ON >= (1 << TEMP_W)) || (COOL_OFF >= (1 << TEMP_W))) begin : g_chk_range
    $error("thresholds must fit in TEMP_W bits");
  end
  if (MIN_DWELL < 1) begin : g_chk_dwell
    $error("MIN_DWELL must be at least 1");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          heat_ok, cool_ok, held, dwell_done;

  always_comb begin
    heat_ok    = (mode == AUTO) || (mode == HEAT_ONLY);
    cool_ok    = (mode == AUTO) || (mode == COOL_ONLY);
    held       = (mode == OFF) || !en;
    dwell_done = (cnt_q == '0);
    state_d    = state_q;

    // Forced exits ignore dwell; threshold moves wait for the timer.
    case (state_q)
      IDLE: begin
        if (!held && dwell_done) begin
          if (temp <= C_HEAT_ON && heat_ok)      state_d = HEAT;
          else if (temp >= C_COOL_ON && cool_ok) state_d = COOL;
        end
      end
      HEAT: begin
        if (held || mode == COOL_ONLY)           state_d = IDLE;
        else if (dwell_done && temp >= C_HEAT_OFF) state_d = IDLE;
      end
      COOL: begin
        if (held || mode == HEAT_ONLY)           state_d = IDLE;
        else if (dwell_done && temp <= C_COOL_OFF) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = DWELL_LOAD;
    else if (dwell_done)    cnt_d = '0;
    else                    cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign heating = state_q[0];
  assign cooling = state_q[1];

endmodule

`default_nettype wire

// File: rtl/ac_zone_ctrl.sv
// ============================================================
// ac_zone_ctrl : N_ZONES independent air-conditioning zone FSMs
// Rev 1.0
// ============================================================
`default_nettype none

module ac_zone_ctrl
  import ac_pkg::*;
#(
  parameter int N_ZONES   = 4,
  parameter int TEMP_W    = 5,
  parameter int HEAT_ON   = 18,
  parameter int HEAT_OFF  = 20,
  parameter int COOL_ON   = 22,
  parameter int COOL_OFF  = 20,
  parameter int MIN_DWELL = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  mode,
  input  logic [N_ZONES-1:0]          zone_en,
  input  logic [N_ZONES*TEMP_W-1:0]   temperature,
  output logic [N_ZONES-1:0]          heating,
  output logic [N_ZONES-1:0]          cooling,
  output logic                        any_active
);

  if (N_ZONES < 1) begin : g_chk_zones
    $error("N_ZONES must be at least 1");
  end

  mode_e mode_sel;
  assign mode_sel = mode_e'(mode);

  for (genvar i = 0; i < N_ZONES; i++) begin : g_zone
    ac_zone_fsm #(
      .TEMP_W    (TEMP_W),
      .HEAT_ON   (HEAT_ON),
      .HEAT_OFF  (HEAT_OFF),
      .COOL_ON   (COOL_ON),
      .COOL_OFF  (COOL_OFF),
      .MIN_DWELL (MIN_DWELL)
    ) u_fsm (
      .clk     (clk),
      .rst_n   (rst_n),
      .mode    (mode_sel),
      .en      (zone_en[i]),
      .temp    (temperature[i*TEMP_W +: TEMP_W]),
      .heating (heating[i]),
      .cooling (cooling[i])
    );
  end

  assign any_active = |{heating, cooling};

endmodule

`default_nettype wire

// File: tb/tb_ac_zone_ctrl.sv
// ============================================================
// tb_ac_zone_ctrl : directed + random bench with a behavioural zone model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_ac_zone_ctrl;

  localparam int NZ = 4;
  localparam int TW = 5;
  localparam int HEAT_ON = 18, HEAT_OFF = 20, COOL_ON = 22, COOL_OFF = 20;
  localparam int MIN_DWELL = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        mode = 2'd1;
  logic [NZ-1:0]     zone_en = '1;
  logic [NZ*TW-1:0]  temperature = '0;
  logic [NZ-1:0]     heating, cooling;
  logic              any_active;

  int n_vec = 0;
  int n_err = 0;

  // Model: zone activity 0 idle / 1 heat / 2 cool / 3 corrupted, plus edges since last change.
  int m_st  [NZ] = '{default: 0};
  int m_age [NZ] = '{default: MIN_DWELL};

  ac_zone_ctrl #(
    .N_ZONES(NZ), .TEMP_W(TW), .HEAT_ON(HEAT_ON), .HEAT_OFF(HEAT_OFF),
    .COOL_ON(COOL_ON), .COOL_OFF(COOL_OFF), .MIN_DWELL(MIN_DWELL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .zone_en(zone_en),
    .temperature(temperature), .heating(heating), .cooling(cooling),
    .any_active(any_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    int t, md, nx;
    bit en, ok, hold;
    if (!rst_n) begin
      for (int i = 0; i < NZ; i++) begin
        m_st[i]  = 0;
        m_age[i] = MIN_DWELL;
      end
    end else begin
      for (int i = 0; i < NZ; i++) begin
        t    = int'(temperature[i*TW +: TW]);
        md   = int'(mode);
        en   = zone_en[i];
        ok   = (m_age[i] >= MIN_DWELL - 1);
        hold = (md == 0) || !en;
        nx   = m_st[i];
        if (m_st[i] == 3) nx = 0;
        else if (m_st[i] == 1) begin
          if (hold || md == 3 || (ok && t >= HEAT_OFF)) nx = 0;
        end else if (m_st[i] == 2) begin
          if (hold || md == 2 || (ok && t <= COOL_OFF)) nx = 0;
        end else if (!hold && ok) begin
          if (t <= HEAT_ON && (md == 1 || md == 2))      nx = 1;
          else if (t >= COOL_ON && (md == 1 || md == 3)) nx = 2;
        end
        if (nx != m_st[i]) m_age[i] = 0;
        else if (m_age[i] < 1000) m_age[i] = m_age[i] + 1;
        m_st[i] = nx;
      end
    end
  end

  always @(negedge clk) begin
    logic [NZ-1:0] eh, ec;
    logic          ea;
    for (int i = 0; i < NZ; i++) begin
      eh[i] = (m_st[i] == 1) || (m_st[i] == 3);
      ec[i] = (m_st[i] == 2) || (m_st[i] == 3);
    end
    ea = |{eh, ec};
    n_vec++;
    if ({heating, cooling, any_active} !== {eh, ec, ea}) begin
      n_err++;
      $display("FAIL model_cmp t=%0t heat=%b cool=%b any=%b expected heat=%b cool=%b any=%b",
               $time, heating, cooling, any_active, eh, ec, ea);
    end
    n_vec++;
    if ((heating & cooling) !== '0) begin
      n_err++;
      $display("FAIL overlap t=%0t heat&cool=%b expected 0", $time, heating & cooling);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic set_t(input int z, input int v);
    temperature[z*TW +: TW] = TW'(v);
  endtask

  task automatic set_all(input int v);
    for (int z = 0; z < NZ; z++) set_t(z, v);
  endtask

  initial begin
    set_all(20);
    repeat (2) @(negedge clk);
    chk("rst_heat", 32'(heating), 0);
    chk("rst_cool", 32'(cooling), 0);
    chk("rst_any", 32'(any_active), 0);

    // Reset and basic heat cycle on zone 0
    rst_n = 1'b1;
    set_t(0, 17);
    @(negedge clk);
    chk("heat0_entry", 32'(heating[0]), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_heat", 32'(heating), 0);
    chk("async_rst_any", 32'(any_active), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("heat0_reentry", 32'(heating[0]), 1);
    set_t(0, 20);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk("heat0_dwell", 32'(heating[0]), (j < 4) ? 1 : 0);
    end

    // Dwell on zone 1
    set_t(1, 23);
    @(negedge clk);
    chk("cool1_entry", 32'(cooling[1]), 1);
    set_t(1, 19);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk("cool1_dwell", 32'(cooling[1]), (j < 4) ? 1 : 0);
    end
    set_t(1, 23);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk("cool1_idle_dwell", 32'(cooling[1]), (j == 4) ? 1 : 0);
    end
    set_t(1, 20);
    repeat (5) @(negedge clk);
    chk("cool1_exit", 32'(cooling[1]), 0);

    // Hysteresis band on zone 2
    for (int v = 19; v <= 21; v++) begin
      set_t(2, v);
      @(negedge clk);
      chk("band_idle", 32'({heating[2], cooling[2]}), 0);
    end
    set_t(2, 22);
    @(negedge clk);
    chk("band_cool_on", 32'(cooling[2]), 1);
    set_t(2, 21);
    repeat (5) begin
      @(negedge clk);
      chk("band_cool_hold", 32'(cooling[2]), 1);
    end
    set_t(2, 20);
    @(negedge clk);
    chk("band_cool_off", 32'(cooling[2]), 0);

    // Mode override on zone 3
    set_t(3, 15);
    @(negedge clk);
    chk("heat3_entry", 32'(heating[3]), 1);
    @(negedge clk);
    mode = 2'd3;
    @(negedge clk);
    chk("cool_only_force", 32'(heating[3]), 0);
    mode = 2'd1;

    // Zone enable
    zone_en = 4'b1011;
    set_all(15);
    repeat (6) @(negedge clk);
    chk("en_heat", 32'(heating), 32'h0000_000b);
    zone_en[0] = 1'b0;
    @(negedge clk);
    chk("en_clear", 32'(heating), 32'h0000_000a);
    mode = 2'd0;
    @(negedge clk);
    chk("off_heat", 32'(heating), 0);
    chk("off_cool", 32'(cooling), 0);
    chk("off_any", 32'(any_active), 0);

    // Temperature extremes
    mode = 2'd1;
    zone_en = '1;
    set_all(0);
    repeat (6) @(negedge clk);
    chk("temp0_heat", 32'(heating), 32'h0000_000f);
    set_all(31);
    repeat (10) @(negedge clk);
    chk("temp31_cool", 32'(cooling), 32'h0000_000f);
    chk("temp31_heat", 32'(heating), 0);

    // Random run, model-checked every cycle
    repeat (300) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) zone_en[$urandom_range(0, NZ-1)] ^= 1'b1;
      for (int z = 0; z < NZ; z++) begin
        if ($urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 15) == 0) set_t(z, ($urandom_range(0, 1) == 0) ? 0 : 31);
          else set_t(z, $urandom_range(14, 26));
        end
      end
    end

    // Corrupted state encoding on zone 0
    mode = 2'd1;
    zone_en = '1;
    set_all(20);
    repeat (12) @(negedge clk);
    #1;
    force dut.g_zone[0].u_fsm.state_q = ac_pkg::ILLEGAL;
    m_st[0] = 3;
    #1 chk("illegal_decode", 32'({heating[0], cooling[0]}), 3);
    release dut.g_zone[0].u_fsm.state_q;
    @(negedge clk);
    chk("illegal_recover", 32'({heating[0], cooling[0]}), 0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
